counter_hours: RTL
==================

Name: counter_hours

Overview:
- Hours stage of the clock chain.
- Consumes the one-cycle tick_hour pulse produced by the minutes stage and keeps the hour of day (0..23) in an internal binary register.
- Presents the hour as registered BCD digits in 24 h or 12 h (AM/PM) format, and emits a one-cycle tick_day at midnight rollover toward the date stage.
- Supports manual up/down adjustment in set mode.

Parameters:
- RESET_HOUR, 0: hour loaded on reset, binary, legal range 0..23. Values above 23 are an elaboration error.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- mode_hour  input  1  1 = run (follow tick_hour); 0 = set (up/down adjust)
- fmt_24  input  1  1 = 24 h display; 0 = 12 h display
- up  input  1  set-mode increment; one-cycle pulse from the debounced key
- down  input  1  set-mode decrement; one-cycle pulse from the debounced key
- tick_hour  input  1  one-cycle pulse from the minutes stage at the 59→00 wrap
- hour_unit  output  4  BCD units digit
- hour_ten  output  4  BCD tens digit
- pm  output  1  12 h mode: 1 for hours 12..23; forced 0 in 24 h mode
- tick_day  output  1  one-cycle pulse on the 23→00 wrap in run mode

Behaviour:

Reset:
- rst asserted: hour register = RESET_HOUR, immediately, no clock needed.
- hour_unit/hour_ten/pm = conversion of RESET_HOUR under 24 h format. For the default 0: 0,0,0.
- tick_day = 0.
- Reset mid-operation discards any pending tick or key press.

Run mode (mode_hour = 1):
- tick_hour = 1: hour ← (hour == 23) ? 0 : hour + 1.
- tick_day = 1 for exactly the cycle following the edge on which 23→0 occurred; otherwise 0.
- tick_hour = 0: hour holds, tick_day = 0.
- up and down are ignored.

Set mode (mode_hour = 0):
- {up, down} = 10: hour ← hour + 1 mod 24.
- {up, down} = 01: hour ← hour − 1 mod 24, so 0 → 23.
- {up, down} = 00 or 11: hold.
- tick_hour is ignored and the pulse is lost; no catch-up.
- tick_day is held 0, including for an up-wrap from 23 to 0.
- Each cycle an input is asserted counts as one step; the block does not edge-detect.

Output conversion:
- Outputs are registered and updated on every edge from the next-hour value and the current fmt_24.
- Latency: an hour change appears on the same edge that changes the hour register.
- A fmt_24 change is reflected on the next edge with no change to the hour register.
- 24 h format: ten = h / 10, unit = h mod 10, pm = 0.
- 12 h format:
  - h = 0 → 12, pm = 0
  - h = 1..11 → h, pm = 0
  - h = 12 → 12, pm = 1
  - h = 13..23 → h − 12, pm = 1
- hour_ten is only ever 0, 1 or 2. hour_unit is 0..9.
- Internal hour register is 5 bits and never holds a value above 23.

Decomposition:
- Shared package clock_pkg:
  - HOURS_PER_DAY = 24, LAST_HOUR = 23, NOON = 12, BCD_W = 4.
  - A bcd_digit typedef shared with the minutes/seconds stages.
- One sub-module, bin_hour_to_bcd: purely combinational.
  - Inputs: 5-bit hour, fmt_24.
  - Outputs: ten, unit, pm.
  - Instantiated once on the next-hour value, feeding the output registers.

Test Plan:
- Reset with RESET_HOUR = 0, fmt_24 = 1 → ten = 0, unit = 0, pm = 0, tick_day = 0, asynchronously before any clk edge.
- Run mode, fmt_24 = 1, from 22: two tick_hour pulses 5 cycles apart → 2/3 after the first; 0/0 after the second with tick_day high for exactly one cycle; no tick_day after the first.
- fmt_24 = 0, stepping hour through 0, 11, 12, 13, 23 → displays 1/2 pm = 0; 1/1 pm = 0; 1/2 pm = 1; 0/1 pm = 1; 1/1 pm = 1. Toggling to fmt_24 = 1 at hour 13 → 1/3 pm = 0 on the next edge.
- Set mode at hour 0: down pulse → 2/3. Then up pulse → 0/0 with tick_day = 0. up and down together → hold. tick_hour pulse in set mode → hold.
- Run mode, tick_hour asserted while up = 1 → only +1 applied. Switching mode_hour to 0 on the same cycle as tick_hour → tick ignored, hour unchanged.
- Assert rst mid-count at hour 17 during a tick_hour pulse → outputs return to the RESET_HOUR conversion immediately, tick_day = 0. After release, the next tick_hour → 0/1.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants and types for the seconds/minutes/hours clock chain.
package clock_pkg;

   localparam int unsigned HOURS_PER_DAY = 24;
   localparam int unsigned LAST_HOUR     = 23;
   localparam int unsigned NOON          = 12;
   localparam int unsigned BCD_W         = 4;
   localparam int unsigned HOUR_W        = $clog2(HOURS_PER_DAY);

   typedef logic [BCD_W-1:0]  bcd_digit;
   typedef logic [HOUR_W-1:0] hour_t;

endpackage : clock_pkg

// File: rtl/bin_hour_to_bcd.sv
// Binary hour (0..23) to two BCD digits plus PM flag, 24 h or 12 h display.
module bin_hour_to_bcd
   import clock_pkg::*;
(
   input  logic [HOUR_W-1:0] i_hour,
   input  logic              i_fmt_24,
   output logic [BCD_W-1:0]  o_ten_c,
   output logic [BCD_W-1:0]  o_unit_c,
   output logic              o_pm_c
);

   localparam int unsigned TEN    = 10;
   localparam int unsigned TWENTY = 20;

   logic [HOUR_W-1:0] w_disp;

   // Fold into the 12 h range when needed, then split into tens/units.
   always_comb begin
      w_disp   = i_hour;
      o_pm_c   = 1'b0;
      o_ten_c  = '0;
      o_unit_c = '0;
      if (!i_fmt_24) begin
         o_pm_c = (i_hour >= HOUR_W'(NOON));
         if (i_hour == '0) begin
            w_disp = HOUR_W'(NOON);
         end else if (i_hour > HOUR_W'(NOON)) begin
            w_disp = i_hour - HOUR_W'(NOON);
         end
      end
      if (w_disp >= HOUR_W'(TWENTY)) begin
         o_ten_c  = BCD_W'(2);
         o_unit_c = BCD_W'(w_disp - HOUR_W'(TWENTY));
      end else if (w_disp >= HOUR_W'(TEN)) begin
         o_ten_c  = BCD_W'(1);
         o_unit_c = BCD_W'(w_disp - HOUR_W'(TEN));
      end else begin
         o_unit_c = BCD_W'(w_disp);
      end
   end

endmodule : bin_hour_to_bcd

// File: rtl/counter_hours.sv
// Hours stage: counts tick_hour pulses 0..23, supports set-mode adjust,
// presents registered BCD digits and a one-cycle tick_day on midnight wrap.
module counter_hours
   import clock_pkg::*;
#(
   parameter int unsigned RESET_HOUR = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode_hour,
   input  logic             fmt_24,
   input  logic             up,
   input  logic             down,
   input  logic             tick_hour,
   output logic [BCD_W-1:0] hour_unit,
   output logic [BCD_W-1:0] hour_ten,
   output logic             pm,
   output logic             tick_day
);

   localparam hour_t    RST_HOUR = HOUR_W'(RESET_HOUR);
   localparam bcd_digit RST_TEN  = BCD_W'(RESET_HOUR / 10);
   localparam bcd_digit RST_UNIT = BCD_W'(RESET_HOUR % 10);

   generate
      if (RESET_HOUR > LAST_HOUR) begin : g_bad_reset_hour
         $error("counter_hours: RESET_HOUR must be in 0..23");
      end
   endgenerate

   hour_t      r_hour;
   hour_t      w_hour_next;
   logic       w_wrap;
   bcd_digit   w_ten;
   bcd_digit   w_unit;
   logic       w_pm;

   // Next-hour selection: run mode follows tick_hour, set mode follows keys.
   always_comb begin
      w_hour_next = r_hour;
      w_wrap      = 1'b0;
      if (mode_hour) begin
         if (tick_hour) begin
            if (r_hour == HOUR_W'(LAST_HOUR)) begin
               w_hour_next = '0;
               w_wrap      = 1'b1;
            end else begin
               w_hour_next = r_hour + HOUR_W'(1);
            end
         end
      end else begin
         case ({up, down})
            2'b10: w_hour_next = (r_hour == HOUR_W'(LAST_HOUR)) ? '0 : r_hour + HOUR_W'(1);
            2'b01: w_hour_next = (r_hour == '0) ? HOUR_W'(LAST_HOUR) : r_hour - HOUR_W'(1);
            default: w_hour_next = r_hour;
         endcase
      end
   end

   bin_hour_to_bcd u_conv (
      .i_hour   (w_hour_next),
      .i_fmt_24 (fmt_24),
      .o_ten_c  (w_ten),
      .o_unit_c (w_unit),
      .o_pm_c   (w_pm)
   );

   // Hour register and display registers, all updated from the next-hour value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hour    <= RST_HOUR;
         hour_ten  <= RST_TEN;
         hour_unit <= RST_UNIT;
         pm        <= 1'b0;
         tick_day  <= 1'b0;
      end else begin
         r_hour    <= w_hour_next;
         hour_ten  <= w_ten;
         hour_unit <= w_unit;
         pm        <= w_pm;
         tick_day  <= w_wrap;
      end
   end

endmodule : counter_hours
